// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Self-checking monitor for the core's data-memory write port. It holds an
//   ordered list of expected (address, data) writes that is loaded while IDLE.
//   After start, each non-scratch write is compared against the head of the
//   list. The block ends in PASS once every entry has matched. It ends in FAIL
//   on the first mismatch, on a timeout, or when started with an empty list.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   clear                synchronous return to IDLE with an empty list
//   ld_valid/adr/data    load one expected entry (IDLE only)
//   start                begin checking (IDLE only)
//   mem_write/data_adr/write_data   monitored core write port
//   done, pass           verdict flags (registered)
//   fail_code            0 none, 1 mismatch, 2 timeout, 3 empty list at start
//   overflow             sticky: a load arrived while the list was full
//   match_count          expected writes matched so far
//   fail_adr, fail_data  the offending write on a mismatch
module mem_write_checker #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int IGN_LO  = 96,
    parameter int IGN_HI  = 96,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_adr,
    input  logic [DW-1:0]            ld_data,
    input  logic                     start,
    input  logic                     mem_write,
    input  logic [AW-1:0]            data_adr,
    input  logic [DW-1:0]            write_data,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               fail_code,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   match_count,
    output logic [AW-1:0]            fail_adr,
    output logic [DW-1:0]            fail_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // The timer can step one past TIMEOUT-1 on the cycle it trips.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] LO    = AW'(IGN_LO);
    localparam logic [AW-1:0] HI    = AW'(IGN_HI);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   adr_mem  [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;

    logic            ld_ok, ld_drop, pop, fail_nx, cap;
    logic [1:0]      code_nx;
    logic            hit, head_ok, full;

    assign full    = (count == FULL);
    assign hit     = mem_write && !((data_adr >= LO) && (data_adr <= HI));
    assign head_ok = (adr_mem[rd_ptr] == data_adr) && (data_mem[rd_ptr] == write_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= S_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_ok    = 1'b0;
        ld_drop  = 1'b0;
        pop      = 1'b0;
        fail_nx  = 1'b0;
        cap      = 1'b0;
        code_nx  = 2'd0;
        case (state)
            S_IDLE: begin
                ld_ok   = ld_valid && !full;
                ld_drop = ld_valid && full;
                // A load in the same cycle as start counts toward non-empty.
                if (start) begin
                    if (count != '0 || ld_ok) begin
                        state_nx = S_RUN;
                    end else begin
                        state_nx = S_FAIL;
                        fail_nx  = 1'b1;
                        code_nx  = 2'd3;
                    end
                end
            end
            S_RUN: begin
                if (hit && head_ok) begin
                    pop = 1'b1;
                    // A completing match wins over a same-cycle timeout.
                    if (count == CW'(1)) begin
                        state_nx = S_PASS;
                    end else if (timer == TLAST) begin
                        state_nx = S_FAIL;
                        fail_nx  = 1'b1;
                        code_nx  = 2'd2;
                    end
                end else if (hit) begin
                    state_nx = S_FAIL;
                    fail_nx  = 1'b1;
                    cap      = 1'b1;
                    code_nx  = 2'd1;
                end else if (timer == TLAST) begin
                    state_nx = S_FAIL;
                    fail_nx  = 1'b1;
                    code_nx  = 2'd2;
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_nx = S_IDLE;
            ld_ok    = 1'b0;
            ld_drop  = 1'b0;
            pop      = 1'b0;
            fail_nx  = 1'b0;
            cap      = 1'b0;
        end
    end

    // List storage carries no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            adr_mem[wr_ptr]  <= ld_adr;
            data_mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 2'd0;
            overflow    <= 1'b0;
            match_count <= '0;
            fail_adr    <= '0;
            fail_data   <= '0;
        end else if (clear) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 2'd0;
            overflow    <= 1'b0;
            match_count <= '0;
            fail_adr    <= '0;
            fail_data   <= '0;
        end else begin
            // Pointers wrap naturally: DEPTH is a power of two.
            if (ld_ok)   wr_ptr   <= wr_ptr + 1'b1;
            if (ld_drop) overflow <= 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                match_count <= match_count + 1'b1;
            end
            count <= count + CW'(ld_ok) - CW'(pop);
            if (state == S_IDLE)     timer <= '0;
            else if (state == S_RUN) timer <= timer + 1'b1;
            if (fail_nx) fail_code <= code_nx;
            if (cap) begin
                fail_adr  <= data_adr;
                fail_data <= write_data;
            end
            done <= (state_nx == S_PASS) || (state_nx == S_FAIL);
            pass <= (state_nx == S_PASS);
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset, clear, ld_valid, start, mem_write;
    logic [31:0] ld_adr, ld_data, data_adr, write_data;

    logic        done, pass, overflow;
    logic [1:0]  fail_code;
    logic [3:0]  match_count;
    logic [31:0] fail_adr, fail_data;

    logic        d2_done, d2_pass, d2_ovf;
    logic [1:0]  d2_fc;
    logic [1:0]  d2_mc;
    logic [31:0] d2_fa, d2_fd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.DEPTH(8), .TIMEOUT(10)) u_dut (
        .clk(clk), .reset(reset), .clear(clear),
        .ld_valid(ld_valid), .ld_adr(ld_adr), .ld_data(ld_data),
        .start(start), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .done(done), .pass(pass), .fail_code(fail_code), .overflow(overflow),
        .match_count(match_count), .fail_adr(fail_adr), .fail_data(fail_data)
    );

    mem_write_checker #(.DEPTH(2), .TIMEOUT(10)) u_d2 (
        .clk(clk), .reset(reset), .clear(clear),
        .ld_valid(ld_valid), .ld_adr(ld_adr), .ld_data(ld_data),
        .start(start), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .done(d2_done), .pass(d2_pass), .fail_code(d2_fc), .overflow(d2_ovf),
        .match_count(d2_mc), .fail_adr(d2_fa), .fail_data(d2_fd)
    );

    // Drive helpers: every one ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_adr = a; ld_data = d; tick(); ld_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; data_adr = a; write_data = d; tick(); mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 0; ld_valid = 0; start = 0; mem_write = 0;
        ld_adr = 0; ld_data = 0; data_adr = 0; write_data = 0;
        #2;
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d exp 0", done); end
        n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0d exp 0", pass); end
        n_chk++; if (fail_code !== 2'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", fail_code); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0d exp 0", overflow); end
        n_chk++; if (match_count !== 4'd0) begin n_fail++; $display("FAIL reset_mc got %0d exp 0", match_count); end
        n_chk++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin n_fail++; $display("FAIL reset_faddr got %0d/%0d exp 0/0", fail_adr, fail_data); end
        tick(); reset = 1'b0; tick();
    endtask

    task automatic test_basic();
        do_clear();
        load(108, 25); go();
        wr(96, 7);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_scratch_done got %0d exp 0", done); end
        wr(96, 3); wr(108, 25);
        n_chk++; if (pass !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL basic_pass got pass=%0d done=%0d exp 1/1", pass, done); end
        n_chk++; if (fail_code !== 2'd0) begin n_fail++; $display("FAIL basic_code got %0d exp 0", fail_code); end
        n_chk++; if (match_count !== 4'd1) begin n_fail++; $display("FAIL basic_mc got %0d exp 1", match_count); end
    endtask

    task automatic test_multi();
        do_clear();
        load(100, 1); load(104, 2); load(108, 3); go();
        wr(100, 1); wr(96, 9); wr(104, 2);
        n_chk++; if (match_count !== 4'd2 || done !== 1'b0) begin n_fail++; $display("FAIL multi_mid got mc=%0d done=%0d exp 2/0", match_count, done); end
        wr(96, 1); wr(108, 3);
        n_chk++; if (pass !== 1'b1 || match_count !== 4'd3) begin n_fail++; $display("FAIL multi_pass got pass=%0d mc=%0d exp 1/3", pass, match_count); end
    endtask

    task automatic test_wrap();
        do_clear();
        load(100, 1); load(104, 2); go();
        wr(100, 1); wr(104, 2);
        n_chk++; if (d2_pass !== 1'b1 || d2_mc !== 2'd2) begin n_fail++; $display("FAIL wrap_run1 got pass=%0d mc=%0d exp 1/2", d2_pass, d2_mc); end
        n_chk++; if (d2_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %0d exp 0", d2_ovf); end
        do_clear();
        n_chk++; if (d2_done !== 1'b0 || d2_mc !== 2'd0) begin n_fail++; $display("FAIL wrap_clear got done=%0d mc=%0d exp 0/0", d2_done, d2_mc); end
        load(108, 5); load(112, 6); go();
        wr(96, 0); wr(108, 5); wr(112, 6);
        n_chk++; if (d2_pass !== 1'b1 || d2_mc !== 2'd2 || d2_fc !== 2'd0) begin n_fail++; $display("FAIL wrap_run2 got pass=%0d mc=%0d code=%0d exp 1/2/0", d2_pass, d2_mc, d2_fc); end
    endtask

    task automatic test_mismatch();
        do_clear();
        load(108, 25); go();
        wr(108, 24);
        n_chk++; if (done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL mism_flags got done=%0d pass=%0d exp 1/0", done, pass); end
        n_chk++; if (fail_code !== 2'd1) begin n_fail++; $display("FAIL mism_code got %0d exp 1", fail_code); end
        n_chk++; if (fail_adr !== 32'd108 || fail_data !== 32'd24) begin n_fail++; $display("FAIL mism_capture got %0d/%0d exp 108/24", fail_adr, fail_data); end
        n_chk++; if (match_count !== 4'd0) begin n_fail++; $display("FAIL mism_mc got %0d exp 0", match_count); end
        wr(108, 25); tick();
        n_chk++; if (pass !== 1'b0 || fail_code !== 2'd1 || fail_data !== 32'd24 || match_count !== 4'd0)
            begin n_fail++; $display("FAIL mism_hold got pass=%0d code=%0d data=%0d mc=%0d exp 0/1/24/0", pass, fail_code, fail_data, match_count); end
        // A mismatch address other than the expected one is captured too.
        do_clear();
        load(108, 25); go(); wr(112, 25);
        n_chk++; if (fail_code !== 2'd1 || fail_adr !== 32'd112) begin n_fail++; $display("FAIL mism_adr got code=%0d adr=%0d exp 1/112", fail_code, fail_adr); end
    endtask

    task automatic test_timeout();
        do_clear();
        load(108, 25); go();
        for (int i = 0; i < 9; i++) wr(96, i);
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_early got done=%0d exp 0", done); end
        tick();
        n_chk++; if (done !== 1'b1 || fail_code !== 2'd2) begin n_fail++; $display("FAIL tmo_fire got done=%0d code=%0d exp 1/2", done, fail_code); end
        do_clear();
        load(108, 25); go();
        for (int i = 0; i < 9; i++) tick();
        wr(108, 25);
        n_chk++; if (pass !== 1'b1 || fail_code !== 2'd0) begin n_fail++; $display("FAIL tmo_lastmatch got pass=%0d code=%0d exp 1/0", pass, fail_code); end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 8; i++) load(32'd200 + 32'(4 * i), 32'(i));
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0d exp 0", overflow); end
        load(300, 99);
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0d exp 1", overflow); end
        // The ninth entry must have been dropped: the original eight all match.
        go();
        for (int i = 0; i < 8; i++) wr(32'd200 + 32'(4 * i), 32'(i));
        n_chk++; if (pass !== 1'b1 || match_count !== 4'd8 || overflow !== 1'b1)
            begin n_fail++; $display("FAIL ovf_run got pass=%0d mc=%0d ovf=%0d exp 1/8/1", pass, match_count, overflow); end
        do_clear();
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0d exp 0", overflow); end
        go();
        n_chk++; if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd3) begin n_fail++; $display("FAIL empty_start got done=%0d pass=%0d code=%0d exp 1/0/3", done, pass, fail_code); end
    endtask

    task automatic test_load_start();
        do_clear();
        ld_valid = 1'b1; ld_adr = 120; ld_data = 7; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL ldst_run got done=%0d exp 0", done); end
        wr(120, 7);
        n_chk++; if (pass !== 1'b1 || match_count !== 4'd1) begin n_fail++; $display("FAIL ldst_pass got pass=%0d mc=%0d exp 1/1", pass, match_count); end
    endtask

    task automatic test_async_reset();
        do_clear();
        load(100, 1); load(104, 2); go();
        wr(100, 1);
        n_chk++; if (match_count !== 4'd1) begin n_fail++; $display("FAIL arst_pre got mc=%0d exp 1", match_count); end
        #1 reset = 1'b1;
        #1;
        n_chk++; if (match_count !== 4'd0 || done !== 1'b0 || fail_code !== 2'd0) begin n_fail++; $display("FAIL arst_async got mc=%0d done=%0d code=%0d exp 0/0/0", match_count, done, fail_code); end
        #1 reset = 1'b0;
        // Back in IDLE: writes no longer do anything and no timeout fires.
        for (int i = 0; i < 12; i++) wr(104, 2);
        n_chk++; if (done !== 1'b0 || match_count !== 4'd0) begin n_fail++; $display("FAIL arst_idle got done=%0d mc=%0d exp 0/0", done, match_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi();
        test_wrap();
        test_mismatch();
        test_timeout();
        test_overflow();
        test_load_start();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Parametrised, synthesizable self-checking monitor for the RISC-V core's data-memory write port. It generalises our single hard-coded "write 25 to address 108" end-of-test check.
- Holds an ordered list of up to DEPTH expected (address, data) writes, loaded before the run.
- Ignores writes that fall inside a configurable scratch address window.
- Reports pass, mismatch or timeout. Sits beside the core in simulation and on FPGA debug builds.

Parameters:
AW, 32, address width
DW, 32, data width
DEPTH, 8, maximum number of expected writes (power of two, >=2)
IGN_LO, 96, lowest ignored (scratch) address, inclusive
IGN_HI, 96, highest ignored address, inclusive
TIMEOUT, 1000, RUN cycles allowed before a timeout failure (>=1)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous return to IDLE; empties the list
ld_valid  in  1  load one expected entry (honoured in IDLE only)
ld_adr  in  AW  expected address
ld_data  in  DW  expected data
start  in  1  begin checking (honoured in IDLE only)
mem_write  in  1  core memory write strobe
data_adr  in  AW  core write address
write_data  in  DW  core write data
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS only
fail_code  out  2  0=none, 1=mismatch, 2=timeout, 3=empty list at start
overflow  out  1  sticky: a load was attempted while the list was full
match_count  out  $clog2(DEPTH)+1  expected writes matched so far
fail_adr  out  AW  address of the mismatching write
fail_data  out  DW  data of the mismatching write

Behaviour:
- Reset (async): state=IDLE, list empty (rd_ptr=wr_ptr=count=0), timer=0, done=0, pass=0, fail_code=0, overflow=0, match_count=0, fail_adr=0, fail_data=0.
- States: IDLE, RUN, PASS, FAIL.
  - PASS and FAIL are terminal. Only reset or clear leaves them.
  - All outputs are registered.
- IDLE:
  - ld_valid with count<DEPTH: write entry at wr_ptr; wr_ptr wraps modulo DEPTH; count+1.
  - ld_valid with count==DEPTH: entry dropped; overflow<=1.
  - start with count>0: go to RUN; timer<=0.
  - start with count==0: go to FAIL with fail_code=3.
  - start and ld_valid in the same cycle: the load is applied first and counts toward the count>0 test.
  - mem_write is ignored in IDLE.
- RUN:
  - timer increments every cycle.
  - A write is "ignored" when mem_write=1 and IGN_LO<=data_adr<=IGN_HI. Ignored writes have no effect.
  - Any other write is compared against the head entry (rd_ptr):
    - Address and data both equal: pop the entry (rd_ptr wraps, count-1), match_count+1.
    - If that pop empties the list: next state PASS.
    - Address or data differs: next state FAIL, fail_code=1, fail_adr/fail_data capture the offending write. The list is not popped.
  - Timeout: timer==TIMEOUT-1 with no completing match in that cycle → FAIL, fail_code=2.
  - Same-cycle priority: completing match beats timeout. Mismatch beats timeout.
  - ld_valid and start are ignored in RUN.
- Outputs:
  - done=1 in PASS and FAIL.
  - pass=1 only in PASS.
  - fail_code and fail_* hold until reset or clear.
- clear (any state):
  - Next cycle: IDLE with empty list.
  - timer, match_count, fail_code, fail_adr, fail_data and overflow all <=0.
  - Priority: reset > clear > everything else.
- Latency: done/pass/fail_code become valid on the rising edge that samples the deciding write. They are visible the cycle after mem_write is asserted.
- Reset mid-RUN: immediate asynchronous return to the reset values.

Test Plan:
- Load (108,25); start; core writes (96,7), (96,3), then (108,25) → the scratch writes are ignored; next cycle pass=1, done=1, fail_code=0, match_count=1.
- Load (100,1),(104,2),(108,3); writes in that order, scratch writes interleaved → PASS, match_count=3. Repeat after clear to exercise pointer wrap with DEPTH=2 (load 2, pass, clear, load 2, pass).
- Load (108,25); write (108,24) → FAIL, fail_code=1, fail_adr=108, fail_data=24, match_count=0. A further write (108,25) changes nothing.
- TIMEOUT=10; load (108,25); start; no non-scratch writes → FAIL with fail_code=2 exactly 10 cycles after start. A second run with the matching write in the timer==9 cycle → PASS.
- DEPTH=8: nine loads → overflow=1 and count stays 8. Start with zero entries → FAIL, fail_code=3.
- Assert reset mid-RUN after one match → outputs return to the reset values asynchronously, before the next clock edge.
